// File: rtl/qpsk_sym_packetizer.sv
// QPSK symbol packetizer: packs strobed {I,Q} symbols into AXI-stream packets.
// Define QPSK_PKT_STORE_FWD_EN for store-and-forward; default is cut-through.
module qpsk_sym_packetizer #(
    parameter int FIFO_AW = 5,
    parameter int SPP_W   = 16
) (
    input  logic             ce_clk,
    input  logic             ce_rst_n,
    input  logic             enable,
    input  logic [SPP_W-1:0] spp,
    input  logic             sym_stb,
    input  logic [31:0]      sym_iq,
    output logic [31:0]      o_tdata,
    output logic             o_tvalid,
    output logic             o_tlast,
    input  logic             o_tready,
    output logic             busy,
    output logic [15:0]      ovf_cnt,
    output logic [15:0]      pkt_cnt
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state;
    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   occ;
    logic [SPP_W-1:0]   spp_q;
    logic [SPP_W-1:0]   rd_cnt;
    logic [SPP_W-1:0]   pkt_len;
    logic               full;
    logic               empty;
    logic               wr_en;
    logic               drop;
    logic               rd_en;
    logic               start_ok;
    logic               last;

    // Full is judged on pre-read occupancy, so a same-cycle read never
    // makes room for a strobe that arrives while full.
    assign full  = occ == (FIFO_AW+1)'(DEPTH);
    assign empty = occ == '0;
    assign wr_en = (state == RUN) && sym_stb && !full;
    assign drop  = (state == RUN) && sym_stb && full;

`ifdef QPSK_PKT_STORE_FWD_EN
    localparam logic [SPP_W-1:0] DEPTH_S = SPP_W'(DEPTH);

    assign pkt_len  = (spp_q > DEPTH_S) ? DEPTH_S : spp_q;
    assign start_ok = (rd_cnt != '0) || (state == DRAIN) ||
                      (SPP_W'(occ) >= pkt_len);
`else
    assign pkt_len  = spp_q;
    assign start_ok = 1'b1;
`endif

    assign o_tvalid = !empty && start_ok;
    assign o_tdata  = o_tvalid ? mem[rd_ptr] : '0;
    assign last     = (rd_cnt == pkt_len - 1'b1) ||
                      ((state == DRAIN) && (occ == (FIFO_AW+1)'(1)));
    assign o_tlast  = o_tvalid && last;
    assign rd_en    = o_tvalid && o_tready;
    assign busy     = state != IDLE;

    always_ff @(posedge ce_clk) begin
        if (wr_en) mem[wr_ptr] <= sym_iq;
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            spp_q   <= SPP_W'(1);
            rd_cnt  <= '0;
            ovf_cnt <= '0;
            pkt_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;

            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase

            if (rd_en) rd_cnt <= o_tlast ? '0 : rd_cnt + 1'b1;
            if (rd_en && o_tlast) pkt_cnt <= pkt_cnt + 1'b1;
            if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state   <= RUN;
                        spp_q   <= (spp == '0) ? SPP_W'(1) : spp;
                        rd_cnt  <= '0;
                        ovf_cnt <= '0;
                        pkt_cnt <= '0;
                    end
                end
                RUN: begin
                    if (!enable) state <= DRAIN;
                end
                DRAIN: begin
                    if (empty) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qpsk_sym_packetizer.sv
// Directed bench for qpsk_sym_packetizer: packetisation, backpressure,
// overflow, drain, spp handling and asynchronous reset.
module tb_qpsk_sym_packetizer;

    logic        ce_clk;
    logic        ce_rst_n;
    logic        enable;
    logic [15:0] spp;
    logic        sym_stb;
    logic [31:0] sym_iq;
    logic [31:0] o_tdata;
    logic        o_tvalid;
    logic        o_tlast;
    logic        o_tready;
    logic        busy;
    logic [15:0] ovf_cnt;
    logic [15:0] pkt_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] bd[$];
    logic        bl[$];
    int          bc[$];

    qpsk_sym_packetizer #(.FIFO_AW(5), .SPP_W(16)) dut (
        .ce_clk   (ce_clk),
        .ce_rst_n (ce_rst_n),
        .enable   (enable),
        .spp      (spp),
        .sym_stb  (sym_stb),
        .sym_iq   (sym_iq),
        .o_tdata  (o_tdata),
        .o_tvalid (o_tvalid),
        .o_tlast  (o_tlast),
        .o_tready (o_tready),
        .busy     (busy),
        .ovf_cnt  (ovf_cnt),
        .pkt_cnt  (pkt_cnt)
    );

    initial ce_clk = 1'b0;
    always #5 ce_clk = ~ce_clk;

    always @(posedge ce_clk) cyc <= cyc + 1;

    // beat capture at the falling edge, away from the active edge
    always @(negedge ce_clk) begin
        if (ce_rst_n && o_tvalid && o_tready) begin
            bd.push_back(o_tdata);
            bl.push_back(o_tlast);
            bc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge ce_clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] d);
        sym_stb = 1'b1;
        sym_iq  = d;
        clk1();
        sym_stb = 1'b0;
    endtask

    task automatic clr();
        bd.delete();
        bl.delete();
        bc.delete();
    endtask

    function automatic logic [31:0] bdat(input int i);
        return (i < bd.size()) ? bd[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic blast(input int i);
        return (i < bl.size()) ? bl[i] : 1'bx;
    endfunction

    task automatic idle_wait();
        enable = 1'b0;
        repeat (3) clk1();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        clr();
    endtask

    initial begin
        ce_rst_n = 1'b1;
        enable   = 1'b0;
        spp      = 16'd0;
        sym_stb  = 1'b0;
        sym_iq   = 32'd0;
        o_tready = 1'b0;
        #1 ce_rst_n = 1'b0;
        #2;
        chk("rst_valid", {31'd0, o_tvalid}, 32'd0);
        chk("rst_last", {31'd0, o_tlast}, 32'd0);
        chk("rst_data", o_tdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {16'd0, ovf_cnt}, 32'd0);
        chk("rst_pkt", {16'd0, pkt_cnt}, 32'd0);
        repeat (2) clk1();
        ce_rst_n = 1'b1;
        clr();
        clk1();

`ifdef QPSK_PKT_STORE_FWD_EN
        spp = 16'd4;
        o_tready = 1'b1;
        enable = 1'b1;
        clk1();
        for (int i = 0; i < 4; i++) begin
            strobe({16'(i + 1), 16'(i + 1)});
            if (i < 3) chk($sformatf("sf_hold%0d", i), {31'd0, o_tvalid}, 32'd0);
            clk1();
            if (i < 3) chk($sformatf("sf_holdb%0d", i), {31'd0, o_tvalid}, 32'd0);
            clk1();
        end
        repeat (4) clk1();
        chk("sf_nbeats", bd.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sf_data%0d", i), bdat(i), {16'(i + 1), 16'(i + 1)});
            chk($sformatf("sf_last%0d", i), {31'd0, blast(i)}, {31'd0, i == 3});
            if (i > 0 && i < bc.size())
                chk($sformatf("sf_gap%0d", i), bc[i] - bc[i-1], 32'd1);
        end
        chk("sf_pkt", {16'd0, pkt_cnt}, 32'd1);
`else
        spp = 16'd4;
        o_tready = 1'b1;
        enable = 1'b1;
        clk1();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_valid0", {31'd0, o_tvalid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            strobe({16'(i + 1), 16'(i + 1)});
            if (i == 0) begin
                chk("t1_first_valid", {31'd0, o_tvalid}, 32'd1);
                chk("t1_first_data", o_tdata, 32'h0001_0001);
            end
        end
        repeat (3) clk1();
        chk("t1_nbeats", bd.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_data%0d", i), bdat(i), {16'(i + 1), 16'(i + 1)});
            chk($sformatf("t1_last%0d", i), {31'd0, blast(i)},
                {31'd0, (i % 4) == 3});
        end
        chk("t1_pkt", {16'd0, pkt_cnt}, 32'd2);
        chk("t1_ovf", {16'd0, ovf_cnt}, 32'd0);
`endif
        idle_wait();

        // backpressure and overflow
        spp = 16'd8;
        o_tready = 1'b0;
        enable = 1'b1;
        clk1();
        for (int i = 0; i < 40; i++) strobe(32'h100 + i);
        chk("t2_ovf", {16'd0, ovf_cnt}, 32'd8);
        chk("t2_valid", {31'd0, o_tvalid}, 32'd1);
        chk("t2_data", o_tdata, 32'h100);
        clk1();
        chk("t2_stall_data", o_tdata, 32'h100);
        chk("t2_stall_last", {31'd0, o_tlast}, 32'd0);
        o_tready = 1'b1;
        repeat (34) clk1();
        chk("t2_nbeats", bd.size(), 32'd32);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("t2_data%0d", i), bdat(i), 32'h100 + i);
            chk($sformatf("t2_last%0d", i), {31'd0, blast(i)},
                {31'd0, (i % 8) == 7});
        end
        chk("t2_pkt", {16'd0, pkt_cnt}, 32'd4);
        idle_wait();

        // drain closes a partial packet; DRAIN strobes are ignored
        spp = 16'd16;
        o_tready = 1'b0;
        enable = 1'b1;
        clk1();
        for (int i = 0; i < 5; i++) strobe(32'h200 + i);
        enable = 1'b0;
        clk1();
        for (int i = 0; i < 3; i++) strobe(32'hdead);
        chk("t3_ovf", {16'd0, ovf_cnt}, 32'd0);
        o_tready = 1'b1;
        repeat (5) clk1();
        chk("t3_busy_last", {31'd0, busy}, 32'd1);
        clk1();
        chk("t3_busy_fall", {31'd0, busy}, 32'd0);
        repeat (3) clk1();
        chk("t3_nbeats", bd.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_data%0d", i), bdat(i), 32'h200 + i);
            chk($sformatf("t3_last%0d", i), {31'd0, blast(i)}, {31'd0, i == 4});
        end
        chk("t3_pkt", {16'd0, pkt_cnt}, 32'd1);
        idle_wait();

        // spp=0 acts as 1; spp change in RUN ignored
        spp = 16'd0;
        enable = 1'b1;
        clk1();
        for (int i = 0; i < 3; i++) strobe(32'h300 + i);
        spp = 16'd3;
        for (int i = 3; i < 6; i++) strobe(32'h300 + i);
        repeat (2) clk1();
        chk("t4a_nbeats", bd.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t4a_last%0d", i), {31'd0, blast(i)}, 32'd1);
        chk("t4a_pkt", {16'd0, pkt_cnt}, 32'd6);
        idle_wait();
        enable = 1'b1;
        clk1();
        for (int i = 0; i < 6; i++) strobe(32'h400 + i);
        repeat (2) clk1();
        chk("t4b_nbeats", bd.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t4b_last%0d", i), {31'd0, blast(i)},
                {31'd0, (i % 3) == 2});
        chk("t4b_pkt", {16'd0, pkt_cnt}, 32'd2);
        idle_wait();

        // asynchronous reset mid-packet
        spp = 16'd4;
        o_tready = 1'b0;
        enable = 1'b1;
        clk1();
        for (int i = 0; i < 4; i++) strobe(32'h500 + i);
        o_tready = 1'b1;
        clk1();
        chk("t5_beat2", o_tdata, 32'h501);
        #2;
        ce_rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("t5_valid", {31'd0, o_tvalid}, 32'd0);
        chk("t5_last", {31'd0, o_tlast}, 32'd0);
        chk("t5_data", o_tdata, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_pkt", {16'd0, pkt_cnt}, 32'd0);
        chk("t5_ovf", {16'd0, ovf_cnt}, 32'd0);
        clk1();
        ce_rst_n = 1'b1;
        clr();
        repeat (5) clk1();
        enable = 1'b1;
        repeat (5) clk1();
        chk("t5_nbeats", bd.size(), 32'd0);
        chk("t5_valid_after", {31'd0, o_tvalid}, 32'd0);
        chk("t5_busy_after", {31'd0, busy}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qpsk_sym_packetizer.md
Name: qpsk_sym_packetizer

Overview:
Takes the bit-synchronised QPSK symbol stream (one 32-bit {I,Q} word per symbol strobe) and packs it into AXI-stream packets of a programmable number of symbols per packet (SPP). Sits between the costas/bit-sync datapath and the AXI wrapper's s_axis_data port inside the QPSK NoC block. Sequences start and stop via an enable bit, buffers symbols across downstream backpressure, and counts dropped symbols and emitted packets.

Parameters:
FIFO_AW, 5, log2 of the symbol FIFO depth (depth = 2^FIFO_AW = 32 entries).
SPP_W, 16, width of the spp input and of the internal packet counters.

Ports:
ce_clk  in  1  compute-engine clock; all logic synchronous to its rising edge.
ce_rst_n  in  1  asynchronous active-low reset.
enable  in  1  run request, from the settings register.
spp  in  SPP_W  symbols per packet; value 0 is treated as 1.
sym_stb  in  1  one-cycle strobe: sym_iq holds a valid symbol.
sym_iq  in  32  symbol {I[15:0], Q[15:0]}.
o_tdata  out  32  packet symbol data.
o_tvalid  out  1  AXI-stream valid.
o_tlast  out  1  last symbol of packet.
o_tready  in  1  AXI-stream ready.
busy  out  1  high when state != IDLE.
ovf_cnt  out  16  dropped-symbol count, saturating.
pkt_cnt  out  16  emitted-packet count, wrapping.

Behaviour:
- Reset (ce_rst_n low, asynchronous): state IDLE; FIFO emptied; o_tvalid=0, o_tlast=0, o_tdata=0, busy=0, ovf_cnt=0, pkt_cnt=0. Reset asserted mid-packet drops the packet and deasserts o_tvalid immediately, with no tlast.
- FSM:
  - IDLE: sym_stb ignored. On enable=1, go to RUN. On that transition, latch spp into spp_q (0 becomes 1), clear ovf_cnt and pkt_cnt, and clear the output symbol counter rd_cnt.
  - RUN: a symbol is written when sym_stb=1 and the FIFO is not full. On enable=0, go to DRAIN. Changes to spp while in RUN are ignored.
  - DRAIN: no writes; sym_stb ignored and not counted. When the FIFO is empty and no beat is pending, go to IDLE. If enable=1 while in DRAIN, stay in DRAIN until empty, then pass through IDLE for one cycle before returning to RUN.
- Full check: uses the occupancy before any same-cycle read. A strobe arriving when full is dropped even if a read happens in the same cycle. Each drop increments ovf_cnt, which saturates at 16'hFFFF.
- Output: the FIFO is first-word-fall-through. A symbol written at edge n gives o_tvalid=1 after edge n, with o_tdata equal to that symbol (1-cycle latency when the FIFO is empty). o_tdata, o_tlast and o_tvalid stay stable while o_tvalid=1 and o_tready=0.
- Beat counting: rd_cnt increments on each handshake (o_tvalid & o_tready). It wraps to 0 on the tlast handshake.
- tlast: o_tlast = (rd_cnt == spp_q-1), or (state==DRAIN and FIFO occupancy==1). A DRAIN therefore closes any partial packet on its final symbol.
- Packet count: pkt_cnt increments on each tlast handshake and wraps.
- Simultaneous write and read with the FIFO not full: both occur and occupancy is unchanged. The pointers wrap modulo depth.

Optional Feature:
Macro QPSK_PKT_STORE_FWD_EN.
- Defined: store-and-forward mode. A packet starts (o_tvalid rises with rd_cnt==0) only when occupancy >= min(spp_q, depth). This guarantees no valid gaps within a packet. If spp_q > depth, packets are clamped to depth symbols (tlast at rd_cnt==depth-1). In DRAIN, a residual partial packet is released regardless of occupancy.
- Undefined: cut-through mode. o_tvalid follows FIFO non-empty, and gaps within a packet are allowed.

Test Plan:
- Basic packetisation: spp=4, enable=1, 8 strobes of 0x00010001..0x00080008, o_tready=1 -> 8 beats in order, tlast on beats 4 and 8, pkt_cnt=2, ovf_cnt=0, first o_tvalid one cycle after the first strobe.
- Backpressure and overflow: spp=8, o_tready=0, 40 strobes -> 32 stored, ovf_cnt=8. Then o_tready=1 -> 32 beats, tlast every 8th beat, pkt_cnt=4.
- Drain of a partial packet: spp=16, 5 strobes, then enable=0 -> 5 beats with tlast on the 5th, busy falls the cycle after the last handshake, state IDLE; strobes during DRAIN are not stored and not counted.
- spp=0 and spp changed mid-run: spp=0 -> every beat has tlast. Changing spp to 3 while in RUN has no effect until a disable/enable cycle.
- Asynchronous reset mid-packet: ce_rst_n pulsed low between clock edges during beat 2 of 4 -> o_tvalid=0 immediately, counters=0, and after release no residual beats are emitted.
- QPSK_PKT_STORE_FWD_EN defined: spp=4, strobes every 3 cycles -> o_tvalid stays 0 until 4 symbols are buffered, then 4 back-to-back beats with no gaps.
